// File: rtl/lfsr_rng.sv
// lfsr_rng: parametrised Fibonacci LFSR random-number source with a req/valid handshake and optional free-run.
// Latency: req accepted at edge t -> valid high in the cycle after edge t+STEPS_PER_REQ; one request per STEPS_PER_REQ+2 cycles.
// Backpressure: none; req is only sampled in IDLE, so the requester holds or re-issues req until valid.
//
// Ports: clk, rst (sync, active-high) | en free-run enable | seed_load/seed_in runtime reseed
//        req request | busy high in SHIFT/DONE | valid one-cycle result pulse | random_out last value
//        lockup recovery pulse (only with LFSR_LOCKUP_DETECT_EN defined; tied 0 otherwise)
// Optional build macro: LFSR_LOCKUP_DETECT_EN (all-zero register is reloaded with SEED).

module lfsr_rng #(
  parameter int              WIDTH         = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'h002D,
  parameter logic [WIDTH-1:0] SEED         = 16'hACE1,
  parameter int              OUT_WIDTH     = 8,
  parameter int              STEPS_PER_REQ = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed_in,
  input  logic                 req,
  output logic                 busy,
  output logic                 valid,
  output logic [OUT_WIDTH-1:0] random_out,
  output logic                 lockup
);

  localparam int CW = (STEPS_PER_REQ > 1) ? $clog2(STEPS_PER_REQ) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(STEPS_PER_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] lfsr_q;
  logic             fb;
  logic [WIDTH-1:0] lfsr_next;

  assign fb        = ^(lfsr_q & TAPS);
  assign lfsr_next = {fb, lfsr_q[WIDTH-1:1]};

`ifdef LFSR_LOCKUP_DETECT_EN
  logic lockup_q;
  assign lockup = lockup_q;
`else
  assign lockup = 1'b0;
`endif

  // The accepting IDLE cycle performs the first shift, so SHIFT performs the
  // remaining STEPS_PER_REQ-1 shifts and spends its counter==0 cycle capturing
  // the result. valid is registered on entry to DONE, so it is high exactly
  // during the DONE cycle and random_out updates together with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q     <= SEED;
      state      <= IDLE;
      counter    <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      random_out <= '0;
`ifdef LFSR_LOCKUP_DETECT_EN
      lockup_q   <= 1'b0;
`endif
    end else begin
`ifdef LFSR_LOCKUP_DETECT_EN
      lockup_q <= 1'b0;
`endif
      if (seed_load) begin
        // A zero seed would lock the register, so fall back to SEED.
        lfsr_q <= (seed_in == '0) ? SEED : seed_in;
        state  <= IDLE;
        busy   <= 1'b0;
        valid  <= 1'b0;
      end else begin
        valid <= 1'b0;
        case (state)
          IDLE: begin
            if (req) begin
              state   <= SHIFT;
              busy    <= 1'b1;
              counter <= CNT_INIT;
              lfsr_q  <= lfsr_next;
            end else if (en) begin
              lfsr_q <= lfsr_next;
            end
          end
          SHIFT: begin
            if (counter == '0) begin
              state      <= DONE;
              valid      <= 1'b1;
              random_out <= lfsr_q[OUT_WIDTH-1:0];
            end else begin
              counter <= counter - 1'b1;
              lfsr_q  <= lfsr_next;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
`ifdef LFSR_LOCKUP_DETECT_EN
        // Recovery overrides whatever step the FSM chose; counting is untouched.
        if (lfsr_q == '0) begin
          lfsr_q   <= SEED;
          lockup_q <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_lfsr_rng.sv
module tb_lfsr_rng;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance, 3 steps per request
  logic       en8 = 1'b0, sl8 = 1'b0, req8 = 1'b0;
  logic [7:0] si8 = 8'h00;
  logic       busy8, valid8, lk8;
  logic [7:0] ro8;

  // default-parameter instance
  logic        en16 = 1'b0, sl16 = 1'b0, req16 = 1'b0;
  logic [15:0] si16 = 16'h0000;
  logic        busy16, valid16, lk16;
  logic [7:0]  ro16;

  // 8-bit instance with an illegal all-zero tap mask
  logic       enz = 1'b0, slz = 1'b0, reqz = 1'b0;
  logic [7:0] siz = 8'h00;
  logic       busyz, validz, lkz;
  logic [7:0] roz;

  lfsr_rng #(.WIDTH(8), .TAPS(8'h2D), .SEED(8'hAD), .OUT_WIDTH(8), .STEPS_PER_REQ(3)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .seed_load(sl8), .seed_in(si8), .req(req8),
    .busy(busy8), .valid(valid8), .random_out(ro8), .lockup(lk8));

  lfsr_rng dut16 (
    .clk(clk), .rst(rst), .en(en16), .seed_load(sl16), .seed_in(si16), .req(req16),
    .busy(busy16), .valid(valid16), .random_out(ro16), .lockup(lk16));

  lfsr_rng #(.WIDTH(8), .TAPS(8'h00), .SEED(8'hAD), .OUT_WIDTH(8), .STEPS_PER_REQ(3)) dutz (
    .clk(clk), .rst(rst), .en(enz), .seed_load(slz), .seed_in(siz), .req(reqz),
    .busy(busyz), .valid(validz), .random_out(roz), .lockup(lkz));

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] step8(input logic [7:0] r);
    return {^(r & 8'h2D), r[7:1]};
  endfunction

  // One clock; outputs sampled 1 time unit after the edge. Any valid pulse
  // from the 8-bit instance is scored against the expected-value queue.
  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (valid8 === 1'b1) begin
      vcount++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid random_out=%h (no request outstanding)", ro8);
      end else begin
        e = exp_q.pop_front();
        if (ro8 !== e) begin
          errors++;
          $display("FAIL scoreboard_value got %h expected %h", ro8, e);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (busy8 !== 1'b0 || valid8 !== 1'b0 || ro8 !== 8'h00 || lk8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b valid=%b out=%h lockup=%b expected 0 0 00 0",
               busy8, valid8, ro8, lk8);
    end
    checks++;
    if (dut8.lfsr_q !== 8'hAD) begin
      errors++;
      $display("FAIL reset_reg8 got %h expected ad", dut8.lfsr_q);
    end
    checks++;
    if (dut16.lfsr_q !== 16'hACE1) begin
      errors++;
      $display("FAIL reset_reg16 got %h expected ace1", dut16.lfsr_q);
    end
  endtask

  task automatic test_free_run();
    logic [7:0] exp_seq [3] = '{8'h56, 8'hAB, 8'hD5};
    do_reset();
    en8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut8.lfsr_q !== exp_seq[i] || valid8 !== 1'b0) begin
        errors++;
        $display("FAIL free_run_step%0d reg=%h valid=%b expected %h 0", i, dut8.lfsr_q, valid8, exp_seq[i]);
      end
    end
    en8 = 1'b0;
    checks++;
    if (ro8 !== 8'h00) begin
      errors++;
      $display("FAIL free_run_out got %h expected 00", ro8);
    end
  endtask

  task automatic test_request();
    int busy_cnt = 0;
    int vidx = -1;
    int v0;
    do_reset();
    exp_q.push_back(step8(step8(step8(8'hAD))));
    v0 = vcount;
    req8 = 1'b1;
    tick();
    req8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (busy8 === 1'b1) busy_cnt++;
      if (valid8 === 1'b1) vidx = k;
      tick();
    end
    checks++;
    if (busy_cnt != 4) begin
      errors++;
      $display("FAIL req_busy_cycles got %0d expected 4", busy_cnt);
    end
    checks++;
    if (vcount - v0 != 1 || vidx != 4) begin
      errors++;
      $display("FAIL req_valid_timing pulses=%0d at_cycle=%0d expected 1 at 4", vcount - v0, vidx);
    end
    checks++;
    if (ro8 !== 8'hD5) begin
      errors++;
      $display("FAIL req_out_held got %h expected d5", ro8);
    end
  endtask

  task automatic test_seed();
    do_reset();
    en16 = 1'b1;
    tick();
    en16 = 1'b0;
    checks++;
    if (dut16.lfsr_q !== 16'h5670) begin
      errors++;
      $display("FAIL seed_step16 got %h expected 5670", dut16.lfsr_q);
    end
    sl16 = 1'b1;
    si16 = 16'h0000;
    tick();
    checks++;
    if (dut16.lfsr_q !== 16'hACE1) begin
      errors++;
      $display("FAIL seed_zero_fallback got %h expected ace1", dut16.lfsr_q);
    end
    si16 = 16'h1234;
    tick();
    sl16 = 1'b0;
    checks++;
    if (dut16.lfsr_q !== 16'h1234) begin
      errors++;
      $display("FAIL seed_load_value got %h expected 1234", dut16.lfsr_q);
    end
  endtask

  // Abort an in-flight request with seed_load, both mid-SHIFT and on the
  // cycle that would otherwise raise valid.
  task automatic test_abort();
    int v0;
    logic [7:0] out_before;
    for (int s = 0; s < 2; s++) begin
      out_before = ro8;
      v0 = vcount;
      req8 = 1'b1;
      tick();
      req8 = 1'b0;
      for (int k = 0; k < s + 1; k++) tick();
      sl8 = 1'b1;
      si8 = (s == 0) ? 8'h3C : 8'h00;
      tick();
      sl8 = 1'b0;
      checks++;
      if (busy8 !== 1'b0 || valid8 !== 1'b0 || dut8.lfsr_q !== ((s == 0) ? 8'h3C : 8'hAD)) begin
        errors++;
        $display("FAIL abort%0d_state busy=%b valid=%b reg=%h expected 0 0 %h",
                 s, busy8, valid8, dut8.lfsr_q, (s == 0) ? 8'h3C : 8'hAD);
      end
      for (int k = 0; k < 6; k++) tick();
      checks++;
      if (vcount != v0 || ro8 !== out_before) begin
        errors++;
        $display("FAIL abort%0d_no_valid pulses=%0d out=%h expected 0 %h", s, vcount - v0, ro8, out_before);
      end
    end
  endtask

  task automatic test_back_to_back();
    int vpos[$];
    logic [7:0] r = 8'hAD;
    int v0;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      r = step8(step8(step8(r)));
      exp_q.push_back(r);
    end
    for (int i = 0; i <= 16; i++) begin
      req8 = (i <= 10);
      tick();
      if (valid8 === 1'b1) vpos.push_back(i);
    end
    req8 = 1'b0;
    checks++;
    if (vpos.size() != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d expected 3", vpos.size());
    end else begin
      checks++;
      if (vpos[0] != 3 || vpos[1] != 8 || vpos[2] != 13) begin
        errors++;
        $display("FAIL b2b_spacing got %0d,%0d,%0d expected 3,8,13", vpos[0], vpos[1], vpos[2]);
      end
    end
    // reset in the middle of SHIFT
    req8 = 1'b1;
    tick();
    req8 = 1'b0;
    tick();
    v0 = vcount;
    do_reset();
    checks++;
    if (busy8 !== 1'b0 || valid8 !== 1'b0 || ro8 !== 8'h00 || lk8 !== 1'b0 || dut8.lfsr_q !== 8'hAD) begin
      errors++;
      $display("FAIL midshift_reset busy=%b valid=%b out=%h lockup=%b reg=%h expected 0 0 00 0 ad",
               busy8, valid8, ro8, lk8, dut8.lfsr_q);
    end
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (vcount != v0) begin
      errors++;
      $display("FAIL midshift_no_valid got %0d pulses expected 0", vcount - v0);
    end
  endtask

  task automatic test_lockup();
    do_reset();
    enz = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    enz = 1'b0;
    checks++;
    if (dutz.lfsr_q !== 8'h00 || lkz !== 1'b0) begin
      errors++;
      $display("FAIL lockup_reach_zero reg=%h lockup=%b expected 00 0", dutz.lfsr_q, lkz);
    end
    tick();
`ifdef LFSR_LOCKUP_DETECT_EN
    checks++;
    if (dutz.lfsr_q !== 8'hAD || lkz !== 1'b1) begin
      errors++;
      $display("FAIL lockup_recover reg=%h lockup=%b expected ad 1", dutz.lfsr_q, lkz);
    end
    tick();
    checks++;
    if (lkz !== 1'b0) begin
      errors++;
      $display("FAIL lockup_pulse_width lockup=%b expected 0", lkz);
    end
`else
    tick();
    checks++;
    if (dutz.lfsr_q !== 8'h00 || lkz !== 1'b0) begin
      errors++;
      $display("FAIL lockup_stuck reg=%h lockup=%b expected 00 0", dutz.lfsr_q, lkz);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_request();
    test_abort();
    test_seed();
    test_back_to_back();
    test_lockup();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d outstanding expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
